// File: rtl/ysyx_24100006_axi_sram_pkg.sv
// Shared definitions for the ysyx_24100006 AXI blocks: FSM encodings,
// default memory base address and a byte-address to word-offset helper.
package ysyx_24100006_pkg;

   localparam logic [31:0] ADDR_BASE_DEFAULT = 32'h8000_0000;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      R_WAIT = 3'd1,
      R_DATA = 3'd2,
      W_DATA = 3'd3,
      W_RESP = 3'd4
   } axi_state_e;

   // Word offset from the mapped base; callers keep only the low index bits.
   function automatic logic [31:0] word_offset(input logic [31:0] addr,
                                               input logic [31:0] base);
      return (addr - base) >> 2;
   endfunction

endpackage

// File: rtl/ysyx_24100006_sram_array.sv
// Word-organised storage: combinational read port, byte-enabled write port.
// Contents are deliberately not reset.
module ysyx_24100006_sram_array #(
   parameter int DEPTH_WORDS = 4096
) (
   input  logic                           clk,
   input  logic                           i_wen,
   input  logic [$clog2(DEPTH_WORDS)-1:0] i_waddr,
   input  logic [31:0]                    i_wdata,
   input  logic [3:0]                     i_wstrb,
   input  logic [$clog2(DEPTH_WORDS)-1:0] i_raddr,
   output logic [31:0]                    o_rdata
);

   logic [31:0] r_mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (i_wen) begin
         for (int i = 0; i < 4; i++) begin
            if (i_wstrb[i]) begin
               r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
            end
         end
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ysyx_24100006_axi_sram.sv
// Single-outstanding AXI slave in front of a word SRAM: INCR bursts,
// fixed read latency, byte-strobed writes, writes win over simultaneous reads.
module ysyx_24100006_axi_sram
   import ysyx_24100006_pkg::*;
#(
   parameter logic [31:0] ADDR_BASE   = ADDR_BASE_DEFAULT,
   parameter int          DEPTH_WORDS = 4096,
   parameter int          RD_LAT      = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        awvalid,
   output logic        awready,
   input  logic [31:0] awaddr,
   input  logic [7:0]  awlen,
   input  logic [2:0]  awsize,
   input  logic        wvalid,
   output logic        wready,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic        wlast,
   output logic        bvalid,
   input  logic        bready,
   input  logic        arvalid,
   output logic        arready,
   input  logic [31:0] araddr,
   input  logic [7:0]  arlen,
   input  logic [2:0]  arsize,
   output logic        rvalid,
   input  logic        rready,
   output logic [31:0] rdata,
   output logic        rlast
);

   localparam int AW = $clog2(DEPTH_WORDS);

   axi_state_e  r_state, w_stateNext;
   logic [31:0] r_addr, w_addrNext;
   logic [7:0]  r_len, w_lenNext;
   logic [7:0]  r_beat, w_beatNext;
   logic [3:0]  r_cnt, w_cntNext;

   logic          w_awFire, w_arFire, w_rFire, w_wFire;
   logic [31:0]   w_wordOff, w_memRdata;
   logic [AW-1:0] w_idx;
   logic          w_unused;

   // Holding arready low while awvalid is up makes the write win a tie.
   assign awready = (r_state == IDLE);
   assign arready = (r_state == IDLE) && !awvalid;
   assign wready  = (r_state == W_DATA);
   assign bvalid  = (r_state == W_RESP);
   assign rvalid  = (r_state == R_DATA);
   assign rlast   = rvalid && (r_beat == r_len);
   assign rdata   = rvalid ? w_memRdata : 32'h0;

   assign w_awFire = awvalid && awready;
   assign w_arFire = arvalid && arready;
   assign w_rFire  = rvalid && rready;
   assign w_wFire  = wvalid && wready;

   assign w_wordOff = word_offset(r_addr, ADDR_BASE);
   assign w_idx     = w_wordOff[AW-1:0];
   assign w_unused  = ^{awlen, awsize, arsize, w_wordOff[31:AW]};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
         r_addr  <= 32'h0;
         r_len   <= 8'h0;
         r_beat  <= 8'h0;
         r_cnt   <= 4'h0;
      end else begin
         r_state <= w_stateNext;
         r_addr  <= w_addrNext;
         r_len   <= w_lenNext;
         r_beat  <= w_beatNext;
         r_cnt   <= w_cntNext;
      end
   end

   always_comb begin
      w_stateNext = r_state;
      w_addrNext  = r_addr;
      w_lenNext   = r_len;
      w_beatNext  = r_beat;
      w_cntNext   = r_cnt;
      case (r_state)
         IDLE: begin
            if (w_awFire) begin
               w_addrNext  = awaddr;
               w_stateNext = W_DATA;
            end else if (w_arFire) begin
               w_addrNext  = araddr;
               w_lenNext   = arlen;
               w_beatNext  = 8'h0;
               w_cntNext   = 4'(RD_LAT - 1);
               // With a one-cycle latency there is nothing to wait for.
               w_stateNext = (RD_LAT <= 1) ? R_DATA : R_WAIT;
            end
         end
         R_WAIT: begin
            w_cntNext = r_cnt - 4'h1;
            if (r_cnt <= 4'h1) begin
               w_stateNext = R_DATA;
            end
         end
         R_DATA: begin
            if (w_rFire) begin
               if (rlast) begin
                  w_stateNext = IDLE;
               end else begin
                  w_beatNext = r_beat + 8'h1;
                  w_addrNext = r_addr + 32'h4;
               end
            end
         end
         W_DATA: begin
            if (w_wFire) begin
               w_addrNext = r_addr + 32'h4;
               if (wlast) begin
                  w_stateNext = W_RESP;
               end
            end
         end
         W_RESP: begin
            if (bready) begin
               w_stateNext = IDLE;
            end
         end
         default: w_stateNext = IDLE;
      endcase
   end

   ysyx_24100006_sram_array #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_array (
      .clk     (clk),
      .i_wen   (w_wFire),
      .i_waddr (w_idx),
      .i_wdata (wdata),
      .i_wstrb (wstrb),
      .i_raddr (w_idx),
      .o_rdata (w_memRdata)
   );

endmodule

// File: tb/tb_ysyx_24100006_axi_sram.sv
// Randomised bench for ysyx_24100006_axi_sram with a word/byte-lane memory
// model and a per-cycle R channel checker.
module tb_ysyx_24100006_axi_sram;

   localparam logic [31:0] BASE   = 32'h8000_0000;
   localparam int          DEPTH  = 4096;
   localparam int          RD_LAT = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
   logic        arvalid, arready, rvalid, rready, rlast;
   logic [31:0] awaddr, araddr, wdata, rdata;
   logic [7:0]  awlen, arlen;
   logic [2:0]  awsize, arsize;
   logic [3:0]  wstrb;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  known;
      logic        last;
   } beat_t;

   logic [31:0] modelMem [DEPTH];
   logic [3:0]  modelKnown [DEPTH];
   beat_t       expQ [$];
   logic [31:0] wrData [$];
   logic [3:0]  wrStrb [$];
   logic [31:0] lastBeatData;
   int          tests = 0;
   int          failures = 0;

   ysyx_24100006_axi_sram #(
      .ADDR_BASE   (BASE),
      .DEPTH_WORDS (DEPTH),
      .RD_LAT      (RD_LAT)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .awvalid (awvalid),
      .awready (awready),
      .awaddr  (awaddr),
      .awlen   (awlen),
      .awsize  (awsize),
      .wvalid  (wvalid),
      .wready  (wready),
      .wdata   (wdata),
      .wstrb   (wstrb),
      .wlast   (wlast),
      .bvalid  (bvalid),
      .bready  (bready),
      .arvalid (arvalid),
      .arready (arready),
      .araddr  (araddr),
      .arlen   (arlen),
      .arsize  (arsize),
      .rvalid  (rvalid),
      .rready  (rready),
      .rdata   (rdata),
      .rlast   (rlast)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic int wordIdx(input logic [31:0] a);
      logic [31:0] off;
      off = (a - BASE) >> 2;
      return int'(off & 32'(DEPTH - 1));
   endfunction

   function automatic void modelWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      int w;
      w = wordIdx(a);
      for (int i = 0; i < 4; i++) begin
         if (s[i]) begin
            modelMem[w][8*i +: 8] = d[8*i +: 8];
            modelKnown[w][i] = 1'b1;
         end
      end
   endfunction

   function automatic void pushExpected(input logic [31:0] a, input int n);
      beat_t e;
      int    w;
      for (int b = 0; b < n; b++) begin
         w = wordIdx(a + 32'(4 * b));
         e.data  = modelMem[w];
         e.known = modelKnown[w];
         e.last  = (b == n - 1);
         expQ.push_back(e);
      end
   endfunction

   // Every cycle a beat is offered it must match the oldest outstanding expectation.
   always @(negedge clk) begin
      logic [31:0] mask;
      if (reset && rvalid) begin
         if (expQ.size() == 0) begin
            check("unexpectedRvalid", 32'(rvalid), 32'h0);
         end else begin
            mask = {{8{expQ[0].known[3]}}, {8{expQ[0].known[2]}},
                    {8{expQ[0].known[1]}}, {8{expQ[0].known[0]}}};
            check("rdata", rdata & mask, expQ[0].data & mask);
            check("rlast", 32'(rlast), 32'(expQ[0].last));
            if (rready) begin
               lastBeatData = rdata;
               void'(expQ.pop_front());
            end
         end
      end
   end

   task automatic applyStimulus(input logic [31:0] addr, input int n, input bit gaps);
      int guard, hold;
      @(posedge clk); #1;
      awvalid = 1'b1; awaddr = addr; awlen = 8'(n - 1); awsize = 3'd2;
      guard = 0;
      @(negedge clk);
      while (!awready && guard < 50) begin @(negedge clk); guard++; end
      check("awreadyIdle", 32'(awready), 32'h1);
      @(posedge clk); #1;
      awvalid = 1'b0;
      for (int b = 0; b < n; b++) begin
         if (gaps) begin
            while ($urandom_range(0, 2) == 0) begin
               wvalid = 1'b0;
               @(posedge clk); #1;
            end
         end
         wvalid = 1'b1; wdata = wrData[b]; wstrb = wrStrb[b]; wlast = (b == n - 1);
         @(negedge clk);
         check("wreadyInBurst", 32'(wready), 32'h1);
         @(posedge clk);
         modelWrite(addr + 32'(4 * b), wrData[b], wrStrb[b]);
         #1;
      end
      wvalid = 1'b0; wlast = 1'b0;
      hold = gaps ? $urandom_range(0, 2) : 0;
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         check("bvalidHeld", 32'(bvalid), 32'h1);
         @(posedge clk); #1;
      end
      bready = 1'b1;
      @(negedge clk);
      check("bvalid", 32'(bvalid), 32'h1);
      check("wreadyAfterLast", 32'(wready), 32'h0);
      @(posedge clk); #1;
      bready = 1'b0;
      @(negedge clk);
      check("bvalidDropped", 32'(bvalid), 32'h0);
      check("idleAfterWrite", 32'(awready), 32'h1);
   endtask

   task automatic issueAr(input logic [31:0] addr, input int n);
      int guard;
      @(posedge clk); #1;
      arvalid = 1'b1; araddr = addr; arlen = 8'(n - 1); arsize = 3'd2;
      guard = 0;
      @(negedge clk);
      while (!arready && guard < 50) begin @(negedge clk); guard++; end
      check("arreadyIdle", 32'(arready), 32'h1);
      @(posedge clk); #1;
      arvalid = 1'b0;
   endtask

   task automatic collectRead(input int n, input bit stall);
      int got, c;
      got = 0; c = 0;
      rready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      while (got < n && c < 100) begin
         @(negedge clk);
         c++;
         if (c <= RD_LAT) check("rvalidLatency", 32'(rvalid), 32'(c == RD_LAT));
         if (rvalid && rready) got++;
         @(posedge clk); #1;
         rready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      rready = 1'b0;
      check("readBeatsDone", 32'(got), 32'(n));
      @(negedge clk);
      check("idleAfterRead", 32'(arready), 32'h1);
      check("expQueueDrained", 32'(expQ.size()), 32'h0);
   endtask

   task automatic checkOutput(input logic [31:0] addr, input int n, input bit stall);
      pushExpected(addr, n);
      issueAr(addr, n);
      collectRead(n, stall);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] addr;
      int          got, guard, n, w;

      for (int i = 0; i < DEPTH; i++) begin
         modelMem[i] = 32'h0;
         modelKnown[i] = 4'h0;
      end
      reset = 1'b0;
      awvalid = 0; awaddr = 0; awlen = 0; awsize = 0;
      wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
      arvalid = 0; araddr = 0; arlen = 0; arsize = 0; rready = 0;
      lastBeatData = 0;

      // Outputs while held in reset.
      @(negedge clk); @(negedge clk);
      check("rstAwready", 32'(awready), 32'h1);
      check("rstArready", 32'(arready), 32'h1);
      check("rstWready", 32'(wready), 32'h0);
      check("rstRvalid", 32'(rvalid), 32'h0);
      check("rstRlast", 32'(rlast), 32'h0);
      check("rstBvalid", 32'(bvalid), 32'h0);
      check("rstRdata", rdata, 32'h0);
      reset = 1'b1;

      // Single read of a preloaded word.
      wrData = '{32'hDEAD_BEEF}; wrStrb = '{4'hF};
      applyStimulus(BASE, 1, 1'b0);
      checkOutput(BASE, 1, 1'b0);
      check("singleReadLiteral", lastBeatData, 32'hDEAD_BEEF);

      // Burst of words 4..7, then read it back under backpressure.
      wrData = '{32'h4444_0004, 32'h5555_0005, 32'h6666_0006, 32'h7777_0007};
      wrStrb = '{4'hF, 4'hF, 4'hF, 4'hF};
      applyStimulus(BASE + 32'h10, 4, 1'b1);
      checkOutput(BASE + 32'h10, 4, 1'b1);
      check("burstLastLiteral", lastBeatData, 32'h7777_0007);

      // Byte-lane write merges into an existing word.
      wrData = '{32'h1122_3344}; wrStrb = '{4'hF};
      applyStimulus(BASE + 32'h4, 1, 1'b0);
      wrData = '{32'h0000_AA00}; wrStrb = '{4'b0010};
      applyStimulus(BASE + 32'h4, 1, 1'b0);
      check("modelByteMerge", modelMem[1], 32'h1122_AA44);
      checkOutput(BASE + 32'h4, 1, 1'b0);
      check("byteWriteLiteral", lastBeatData, 32'h1122_AA44);

      // All-zero strobe handshakes but changes nothing.
      wrData = '{32'hFFFF_FFFF}; wrStrb = '{4'b0000};
      applyStimulus(BASE + 32'h4, 1, 1'b0);
      checkOutput(BASE + 32'h4, 1, 1'b0);
      check("zeroStrobeLiteral", lastBeatData, 32'h1122_AA44);

      // Write and read raised together to the same word.
      addr = BASE + 32'h20;
      @(posedge clk); #1;
      awvalid = 1; awaddr = addr; awlen = 0; awsize = 3'd2;
      arvalid = 1; araddr = addr; arlen = 0; arsize = 3'd2;
      @(negedge clk);
      check("simAwready", 32'(awready), 32'h1);
      check("simArreadyBlocked", 32'(arready), 32'h0);
      @(posedge clk); #1;
      awvalid = 0; wvalid = 1; wdata = 32'hCAFE_F00D; wstrb = 4'hF; wlast = 1;
      @(negedge clk);
      check("simWready", 32'(wready), 32'h1);
      check("simArreadyInW", 32'(arready), 32'h0);
      @(posedge clk);
      modelWrite(addr, 32'hCAFE_F00D, 4'hF);
      #1;
      wvalid = 0; wlast = 0; bready = 1;
      @(negedge clk);
      check("simBvalid", 32'(bvalid), 32'h1);
      check("simArreadyInB", 32'(arready), 32'h0);
      @(posedge clk); #1;
      bready = 0;
      pushExpected(addr, 1);
      @(negedge clk);
      check("simArreadyLater", 32'(arready), 32'h1);
      @(posedge clk); #1;
      arvalid = 0;
      collectRead(1, 1'b0);
      check("simReadLiteral", lastBeatData, 32'hCAFE_F00D);

      // Bursts that cross the top word wrap to word 0.
      wrData = '{32'hAAAA_0FFF, 32'hBBBB_0000}; wrStrb = '{4'hF, 4'hF};
      applyStimulus(BASE + 32'((DEPTH - 1) * 4), 2, 1'b0);
      check("modelWrapWord0", modelMem[0], 32'hBBBB_0000);
      checkOutput(BASE + 32'((DEPTH - 1) * 4), 2, 1'b0);
      check("wrapReadLiteral", lastBeatData, 32'hBBBB_0000);

      // Reset pulled during beat 1 of a four-beat read.
      pushExpected(BASE + 32'h10, 4);
      issueAr(BASE + 32'h10, 4);
      rready = 1'b1;
      got = 0; guard = 0;
      while (got < 1 && guard < 50) begin
         @(negedge clk);
         guard++;
         if (rvalid && rready) got++;
         @(posedge clk); #1;
      end
      check("midResetBeat0Taken", 32'(got), 32'h1);
      #2;
      check("midResetBeat1Visible", 32'(rvalid), 32'h1);
      reset = 1'b0;
      #1;
      expQ.delete();
      check("midResetRvalid", 32'(rvalid), 32'h0);
      check("midResetRlast", 32'(rlast), 32'h0);
      check("midResetRdata", rdata, 32'h0);
      check("midResetArready", 32'(arready), 32'h1);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("noResponseAfterReset", 32'(rvalid | bvalid), 32'h0);
      end
      rready = 1'b0;
      checkOutput(BASE + 32'h10, 4, 1'b0);
      check("memoryKeptLiteral", lastBeatData, 32'h7777_0007);

      // Random mix of writes and reads near both ends of memory.
      for (int it = 0; it < 24; it++) begin
         w = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 12))
                                         : int'($urandom_range(DEPTH - 4, DEPTH - 1));
         addr = BASE + 32'(w * 4) + 32'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1) begin
            n = $urandom_range(1, 4);
            wrData.delete(); wrStrb.delete();
            for (int b = 0; b < n; b++) begin
               wrData.push_back($urandom);
               wrStrb.push_back(4'($urandom_range(0, 15)));
            end
            applyStimulus(addr, n, 1'b1);
         end else begin
            checkOutput(addr, $urandom_range(1, 6), 1'($urandom_range(0, 1)));
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule

// File: doc/ysyx_24100006_axi_sram.md
YSYX_24100006_AXI_SRAM -- requirements
Module: ysyx_24100006_axi_sram

Interface
REQ-001 SHALL have parameter ADDR_BASE, default 32'h8000_0000, meaning byte address mapped to word 0.
REQ-002 SHALL have parameter DEPTH_WORDS, default 4096, meaning memory size in 32-bit words (power of two).
REQ-003 SHALL have parameter RD_LAT, default 2, meaning cycles from AR handshake to first rvalid (legal range 1..15).
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have AW channel ports: awvalid in 1, awready out 1, awaddr in 32, awlen in 8, awsize in 3.
REQ-007 SHALL have W channel ports: wvalid in 1, wready out 1, wdata in 32, wstrb in 4, wlast in 1.
REQ-008 SHALL have B channel ports: bvalid out 1, bready in 1.
REQ-009 SHALL have AR channel ports: arvalid in 1, arready out 1, araddr in 32, arlen in 8, arsize in 3.
REQ-010 SHALL have R channel ports: rvalid out 1, rready in 1, rdata out 32, rlast out 1.

Function
REQ-011 SHALL use one FSM with states IDLE, R_WAIT, R_DATA, W_DATA, W_RESP; only one transaction is outstanding at a time.
REQ-012 SHALL assert awready and arready combinationally only in IDLE.
REQ-013 SHALL, in IDLE with awvalid and arvalid both high, accept the write first; the read is accepted on a later IDLE cycle.
REQ-014 SHALL, on AR handshake, latch araddr and arlen, load a latency counter with RD_LAT-1, and enter R_WAIT.
REQ-015 SHALL decrement the counter in R_WAIT and enter R_DATA when it reaches 0, so rvalid first rises exactly RD_LAT cycles after the AR handshake cycle.
REQ-016 SHALL, in R_DATA, hold rvalid high and rdata/rlast stable until rready; each rvalid&rready accepts one beat.
REQ-017 SHALL drive rdata = mem[idx], with idx = ((addr - ADDR_BASE) >> 2) mod DEPTH_WORDS; low two address bits and arsize do not select data.
REQ-018 SHALL, after each accepted non-final beat, increment addr by 4 (INCR) and present the next beat in the following cycle with no extra latency.
REQ-019 SHALL assert rlast on beat number arlen (beats counted from 0); accepting that beat returns the FSM to IDLE.
REQ-020 SHALL, on AW handshake, latch awaddr and enter W_DATA with wready held high.
REQ-021 SHALL, on each wvalid&wready, write byte lane i of mem[idx] only where wstrb[i]=1, then increment addr by 4.
REQ-022 SHALL, on the beat with wlast=1, enter W_RESP with wready low; awlen is informational only.
REQ-023 SHALL hold bvalid high in W_RESP until bready, then return to IDLE.
REQ-024 SHALL wrap idx modulo DEPTH_WORDS; a burst crossing the top word continues at word 0.
REQ-025 SHALL, with wstrb=4'b0000, complete the handshake and leave memory unchanged.
REQ-026 SHALL reflect a completed write in any read whose AR handshake occurs in a later cycle.

Reset
REQ-027 SHALL, while reset is low, force FSM=IDLE, counter=0, latched addr/len=0, and awready=arready=1, wready=rvalid=rlast=bvalid=0, rdata=0.
REQ-028 SHALL, on reset assertion mid-burst, abandon the transaction immediately; no response is issued after reset release.
REQ-029 SHALL NOT clear memory contents on reset.

Structure
REQ-030 SHALL place FSM state encodings and the default ADDR_BASE in the shared ysyx_24100006 package used by the AXI blocks.
REQ-031 SHALL implement storage as one sub-module ysyx_24100006_sram_array: 1 read port (combinational), 1 write port with 4-bit byte enable.

Verification
REQ-032 SHALL cover a single read: preload mem[0]=32'hDEAD_BEEF; AR 32'h8000_0000 with arlen=0 -> rvalid exactly 2 cycles later, rdata=32'hDEAD_BEEF, rlast=1.
REQ-033 SHALL cover a burst read with backpressure: arlen=3 at 32'h8000_0010 with rready toggling -> 4 beats, words 4..7 in order, rlast only on beat 3, data stable while stalled.
REQ-034 SHALL cover a byte write: mem[1]=32'h1122_3344, write 32'h8000_0004 with wdata=32'h0000_AA00 and wstrb=4'b0010 -> bvalid, then readback returns 32'h1122_AA44.
REQ-035 SHALL cover simultaneous requests: awvalid and arvalid asserted in the same IDLE cycle to the same word -> write completes first, and the read returns the new data.
REQ-036 SHALL cover wrap-around: arlen=1 at word DEPTH_WORDS-1 -> beat 1 returns mem[0].
REQ-037 SHALL cover mid-burst reset: reset low during beat 1 of an arlen=3 burst -> rvalid=0 at once, FSM=IDLE, memory intact on a subsequent read.
